// File: rtl/mips_mem_pkg.sv
// Shared types and default I/O map for the multicycle MIPS memory responder.
package mips_mem_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [31:0] DEF_INPORT0_ADDR = 32'h0000_FFF8;
    localparam logic [31:0] DEF_INPORT1_ADDR = 32'h0000_FFFC;
    localparam logic [31:0] DEF_OUTPORT_ADDR = 32'h0000_FFFC;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } mem_state_e;

endpackage

// File: rtl/mips_ram.sv
// Single-port synchronous word RAM, one-cycle read latency, contents not reset.
module mips_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mips_memory.sv
// Memory-side responder: wait-state FSM in front of the word RAM and memory-mapped I/O ports.
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter logic [31:0] INPORT0_ADDR = DEF_INPORT0_ADDR,
    parameter logic [31:0] INPORT1_ADDR = DEF_INPORT1_ADDR,
    parameter logic [31:0] OUTPORT_ADDR = DEF_OUTPORT_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_ready,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] inport_data,
    input  logic                  inport_sel,
    input  logic                  inport_en,
    input  logic                  port_rst,
    output logic [DATA_WIDTH-1:0] outport
);

    mem_state_e            state;
    logic [3:0]            cnt;
    logic [29:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_write_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] io_rdata_q;
    logic [DATA_WIDTH-1:0] inport0;
    logic [DATA_WIDTH-1:0] inport1;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  unused_addr_lsb;

    logic hit_in0, hit_in1, hit_out, ram_hit, use_ram, ram_we;

    assign unused_addr_lsb = ^addr[1:0];

    // Decode uses the captured word address only; byte offset is ignored.
    assign hit_in0 = (addr_q == INPORT0_ADDR[31:2]);
    assign hit_in1 = (addr_q == INPORT1_ADDR[31:2]);
    assign hit_out = (addr_q == OUTPORT_ADDR[31:2]);
    assign ram_hit = (addr_q[29:ADDR_WIDTH] == '0);
    assign use_ram = ram_hit && !hit_in0 && !hit_in1;
    assign ram_we  = (state == StAccess) && is_write_q && ram_hit && !hit_out && !hit_in0;

    mips_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(addr_q[ADDR_WIDTH-1:0]),
        .din (wdata_q),
        .dout(ram_dout)
    );

    // RAM data only arrives in the RESP cycle, so the read result is muxed through there.
    assign rd_data = (state == StResp && !is_write_q) ? (use_ram ? ram_dout : io_rdata_q)
                                                      : rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            busy       <= 1'b0;
            mem_ready  <= 1'b0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        addr_q     <= addr[31:2];
                        wdata_q    <= wr_data;
                        is_write_q <= mem_write;
                        busy       <= 1'b1;
                        cnt        <= 4'(WAIT_CYCLES);
                        state      <= (WAIT_CYCLES > 0) ? StWait : StAccess;
                    end
                end
                StWait: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= StAccess;
                    end
                end
                StAccess: begin
                    io_rdata_q <= hit_in0 ? inport0 : (hit_in1 ? inport1 : '0);
                    mem_ready  <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    if (!is_write_q) begin
                        rd_data_q <= rd_data;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inport0 <= '0;
            inport1 <= '0;
            outport <= '0;
        end else begin
            if (inport_en) begin
                if (inport_sel) begin
                    inport1 <= inport_data;
                end else begin
                    inport0 <= inport_data;
                end
            end
            if (port_rst) begin
                outport <= '0;
            end else if (state == StResp && is_write_q && hit_out) begin
                outport <= wdata_q;
            end
        end
    end

endmodule
